wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage sitting directly upstream of the register-file write port.
- Merges two result sources onto the single write port (rd_we/rd_address/rd_data):
  - the in-order pipeline writeback;
  - out-of-order results from the multi-cycle M-extension divider.
- Buffers divider results in a small FIFO and tracks registers with pending divider results in a scoreboard for the hazard unit.
- Applies back-pressure so that divider results cannot starve.

Parameters:
- NUMBER_OF_REGISTERS, 32, architectural register count; address width is $clog2 of this.
- DATA_WIDTH, 32, register data width.
- FIFO_DEPTH, 2, divider result buffer entries (power of two, ≥2).
- MAX_WAIT, 4, cycles a non-empty FIFO head may be blocked before stall_o is forced.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_valid_i  in  1  pipeline writeback request this cycle.
- pipe_rd_address_i  in  AW  pipeline destination register.
- pipe_rd_data_i  in  DATA_WIDTH  pipeline result.
- div_issue_i  in  1  a divide is issued this cycle; marks its rd busy.
- div_issue_address_i  in  AW  destination of the issued divide.
- div_valid_i  in  1  divider result available.
- div_rd_address_i  in  AW  divider result destination.
- div_rd_data_i  in  DATA_WIDTH  divider result.
- div_ready_o  out  1  FIFO can accept; push = div_valid_i & div_ready_o.
- stall_o  out  1  registered; upstream must hold pipe_valid_i low the following cycle.
- busy_mask_o  out  NUMBER_OF_REGISTERS  scoreboard, bit i set = divider result for xi pending.
- rd_we_o  out  1  register-file write enable (registered).
- rd_address_o  out  AW  register-file write address (registered).
- rd_data_o  out  DATA_WIDTH  register-file write data (registered); also serves as the bypass value for the cycle before the file updates.

Behaviour:
- Reset (rst=1 at an edge), regardless of in-flight traffic:
  - FIFO emptied, scoreboard cleared, wait counter 0.
  - rd_we_o=0, rd_address_o=0, rd_data_o=0, stall_o=0.
  - div_ready_o=1 from the next cycle.
  - In-flight divider results are dropped.
- Arbitration, each cycle:
  - If pipe_valid_i: the pipeline wins; its write is registered to the outputs at the next edge.
  - Else if FIFO non-empty: pop the head and register it to the outputs.
  - Else rd_we_o=0.
  - Latency: request in cycle N → rd_we_o high in cycle N+1 → file updated at the end of N+1.
- x0 handling:
  - Any write with address 0 produces rd_we_o=0; address/data are still registered.
  - A divider push with address 0 is accepted (handshake completes) but not enqueued.
  - div_issue_i with address 0 is ignored.
- FIFO:
  - div_ready_o = !full (combinational).
  - Push and pop in the same cycle are allowed, including when full (pop frees the slot only from the next cycle; div_ready_o stays 0 that cycle).
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- Scoreboard:
  - div_issue_i sets the bit for div_issue_address_i.
  - A FIFO pop clears the bit for the popped address.
  - Set and clear of the same address in the same cycle: set wins.
  - busy_mask_o bit 0 is always 0.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and pipe_valid_i blocks the pop; otherwise resets to 0.
  - stall_o is registered as (count ≥ MAX_WAIT-1 with the block occurring) OR (FIFO full after this cycle's push/pop).
  - While stall_o=1, upstream delivers no pipe_valid_i, so the head drains.
  - If pipe_valid_i arrives anyway, the pipeline still wins and the counter saturates.
- The pipeline must not target a register whose busy bit is set; the hazard unit enforces this using busy_mask_o. The arbiter does not check it.

Decomposition:
- Shared package riscv_pkg:
  - REG_ADDR_W (5) and XLEN (32) constants;
  - X0_ADDR constant;
  - wb_req_t struct {valid, rd_address, rd_data} used for both sources.
- One sub-module: wb_div_fifo, a synchronous FIFO (DEPTH and WIDTH = AW+DATA_WIDTH) with push/pop/full/empty/count.
- The scoreboard and arbiter stay in wb_arbiter.

Test Plan:
- Reset then pipe_valid_i=1, addr 5, data 0xDEADBEEF → next cycle rd_we_o=1, rd_address_o=5, rd_data_o=0xDEADBEEF; the cycle after, rd_we_o=0.
- div_issue addr 7; 3 cycles later div_valid addr 7, data 0x12 with pipe idle → busy_mask_o[7]=1 until the write cycle; rd_we_o=1, addr 7, data 0x12 two cycles after the push; busy_mask_o[7]=0 after the pop.
- Push two divider results (addr 3, 4) while pipe_valid_i is held high → div_ready_o=0 after the second push; stall_o=1 next cycle; after pipe goes low, writes appear in order 3 then 4.
- Pipe writes to addr 0 and divider result to addr 0 → rd_we_o never asserted; FIFO stays empty; busy_mask_o unchanged.
- One FIFO entry blocked by continuous pipe_valid_i → stall_o asserted by the MAX_WAIT-th blocked cycle; head written within 2 cycles of pipe dropping.
- rst=1 with 2 FIFO entries and busy bits set → next cycle: FIFO empty, busy_mask_o=0, rd_we_o=0, stall_o=0, div_ready_o=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register-file geometry and the writeback
// request record used by every result source feeding the register file.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

    // One candidate register-file write; valid qualifies the other fields.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd_address;
        logic [XLEN-1:0]       rd_data;
    } wb_req_t;

endpackage

// File: rtl/wb_div_fifo.sv
// Small synchronous FIFO buffering divider results until the write port is free.
// The head is read combinationally so it can be popped in the cycle it appears.
module wb_div_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign head_data = mem[rd_ptr_reg];

    // A push into a full FIFO is only legal when the head leaves in the same cycle;
    // the write then lands in the slot being vacated.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage write; no reset so the array maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges in-order pipeline results and buffered divider results
// onto the single register-file write port, tracks pending divider destinations,
// and stalls the pipeline when a divider result has waited too long.
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int NUMBER_OF_REGISTERS = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int FIFO_DEPTH          = 2,
    parameter int MAX_WAIT            = 4,
    localparam int AW = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pipe_valid_i,
    input  logic [AW-1:0]                  pipe_rd_address_i,
    input  logic [DATA_WIDTH-1:0]          pipe_rd_data_i,
    input  logic                           div_issue_i,
    input  logic [AW-1:0]                  div_issue_address_i,
    input  logic                           div_valid_i,
    input  logic [AW-1:0]                  div_rd_address_i,
    input  logic [DATA_WIDTH-1:0]          div_rd_data_i,
    output logic                           div_ready_o,
    output logic                           stall_o,
    output logic [NUMBER_OF_REGISTERS-1:0] busy_mask_o,
    output logic                           rd_we_o,
    output logic [AW-1:0]                  rd_address_o,
    output logic [DATA_WIDTH-1:0]          rd_data_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    wb_req_t                  pipe_req;
    wb_req_t                  head_req;
    wb_req_t                  win_req;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;
    logic [CW-1:0]            count_next;
    logic [AW+DATA_WIDTH-1:0] head_data;
    logic                     blocked;
    logic                     stall_next;
    logic                     stall_reg;
    logic [WW-1:0]            wait_reg;
    logic [WW-1:0]            wait_next;
    logic [NUMBER_OF_REGISTERS-1:0] busy_reg;
    logic [NUMBER_OF_REGISTERS-1:0] busy_next;
    logic                     rd_we_reg;
    logic [AW-1:0]            rd_address_reg;
    logic [DATA_WIDTH-1:0]    rd_data_reg;

    assign div_ready_o = !fifo_full;

    // Results for x0 complete the handshake but are discarded instead of buffered.
    assign fifo_push = div_valid_i && div_ready_o && (div_rd_address_i != AW'(X0_ADDR));
    // The pipeline always has priority; the FIFO head drains only on idle pipeline cycles.
    assign fifo_pop  = !pipe_valid_i && !fifo_empty;
    assign blocked   = pipe_valid_i && !fifo_empty;

    wb_div_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AW + DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({div_rd_address_i, div_rd_data_i}),
        .pop       (fifo_pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign pipe_req.valid      = pipe_valid_i;
    assign pipe_req.rd_address = pipe_rd_address_i;
    assign pipe_req.rd_data    = pipe_rd_data_i;

    assign head_req.valid      = !fifo_empty;
    assign head_req.rd_address = head_data[AW+DATA_WIDTH-1:DATA_WIDTH];
    assign head_req.rd_data    = head_data[DATA_WIDTH-1:0];

    // Select this cycle's winner: pipeline first, then the buffered divider head.
    always_comb begin
        win_req = '0;
        if (pipe_valid_i) begin
            win_req = pipe_req;
        end else if (!fifo_empty) begin
            win_req = head_req;
        end
    end

    // Register the write port; x0 writes keep address/data but never enable the file.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_we_reg      <= 1'b0;
            rd_address_reg <= '0;
            rd_data_reg    <= '0;
        end else begin
            rd_we_reg <= win_req.valid && (win_req.rd_address != X0_ADDR);
            if (win_req.valid) begin
                rd_address_reg <= win_req.rd_address;
                rd_data_reg    <= win_req.rd_data;
            end
        end
    end

    // Scoreboard next state: an issue sets a bit, a pop clears it, set wins on a tie; x0 never busy.
    for (genvar gi = 0; gi < NUMBER_OF_REGISTERS; gi++) begin : g_busy
        if (gi == 0) begin : g_x0
            assign busy_next[gi] = 1'b0;
        end else begin : g_xn
            assign busy_next[gi] =
                (div_issue_i && (div_issue_address_i == AW'(gi))) ||
                (busy_reg[gi] && !(fifo_pop && (head_req.rd_address == AW'(gi))));
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // Starvation tracking: count consecutive blocked cycles (saturating) and stall when
    // the head has waited long enough or the buffer will be full next cycle.
    assign count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    assign wait_next  = !blocked ? '0 :
                        (wait_reg >= WW'(MAX_WAIT - 1)) ? wait_reg : wait_reg + WW'(1);
    assign stall_next = (blocked && (wait_reg >= WW'(MAX_WAIT - 1))) ||
                        (count_next == CW'(FIFO_DEPTH));

    // Stall and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_reg  <= '0;
            stall_reg <= 1'b0;
        end else begin
            wait_reg  <= wait_next;
            stall_reg <= stall_next;
        end
    end

    assign stall_o      = stall_reg;
    assign busy_mask_o  = busy_reg;
    assign rd_we_o      = rd_we_reg;
    assign rd_address_o = rd_address_reg;
    assign rd_data_o    = rd_data_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios followed by random traffic, checked
// against a queue-based reference model through an expected-write scoreboard.
module tb_wb_arbiter;
    import riscv_pkg::*;

    localparam int NR       = 32;
    localparam int DW       = 32;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
    localparam int AW       = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pipe_valid_i = 1'b0;
    logic [AW-1:0] pipe_rd_address_i = '0;
    logic [DW-1:0] pipe_rd_data_i = '0;
    logic          div_issue_i = 1'b0;
    logic [AW-1:0] div_issue_address_i = '0;
    logic          div_valid_i = 1'b0;
    logic [AW-1:0] div_rd_address_i = '0;
    logic [DW-1:0] div_rd_data_i = '0;
    logic          div_ready_o;
    logic          stall_o;
    logic [NR-1:0] busy_mask_o;
    logic          rd_we_o;
    logic [AW-1:0] rd_address_o;
    logic [DW-1:0] rd_data_o;

    always #5 clk = ~clk;

    wb_arbiter #(
        .NUMBER_OF_REGISTERS (NR),
        .DATA_WIDTH          (DW),
        .FIFO_DEPTH          (DEPTH),
        .MAX_WAIT            (MAX_WAIT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pipe_valid_i        (pipe_valid_i),
        .pipe_rd_address_i   (pipe_rd_address_i),
        .pipe_rd_data_i      (pipe_rd_data_i),
        .div_issue_i         (div_issue_i),
        .div_issue_address_i (div_issue_address_i),
        .div_valid_i         (div_valid_i),
        .div_rd_address_i    (div_rd_address_i),
        .div_rd_data_i       (div_rd_data_i),
        .div_ready_o         (div_ready_o),
        .stall_o             (stall_o),
        .busy_mask_o         (busy_mask_o),
        .rd_we_o             (rd_we_o),
        .rd_address_o        (rd_address_o),
        .rd_data_o           (rd_data_o)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    // Reference model state (state after the most recent clock edge).
    exp_t          exp_q[$];
    ent_t          m_fifo[$];
    logic [NR-1:0] m_busy = '0;
    int            m_wait = 0;
    logic          m_stall = 1'b0;
    logic [AW-1:0] outst[$];

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic bit in_outst(input logic [AW-1:0] a);
        foreach (outst[i]) if (outst[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle of inputs at the falling edge and advance the model to the next rising edge.
    task automatic drive_cycle(input logic r, input logic pv, input logic [AW-1:0] pa,
                               input logic [DW-1:0] pd, input logic iss, input logic [AW-1:0] ia,
                               input logic dv, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        bit   ready;
        bit   push;
        bit   blocked;
        ent_t head;
        exp_t e;
        @(negedge clk);
        rst = r; pipe_valid_i = pv; pipe_rd_address_i = pa; pipe_rd_data_i = pd;
        div_issue_i = iss; div_issue_address_i = ia;
        div_valid_i = dv; div_rd_address_i = da; div_rd_data_i = dd;
        if (r) begin
            m_fifo.delete();
            m_busy  = '0;
            m_wait  = 0;
            m_stall = 1'b0;
            e.we = 1'b0; e.addr = '0; e.data = '0;
            exp_q.push_back(e);
        end else begin
            ready   = (m_fifo.size() < DEPTH);
            push    = dv && ready;
            blocked = pv && (m_fifo.size() != 0);
            if (pv) begin
                e.we = (pa != 0); e.addr = pa; e.data = pd;
                exp_q.push_back(e);
            end else if (m_fifo.size() != 0) begin
                head = m_fifo.pop_front();
                e.we = 1'b1; e.addr = head.addr; e.data = head.data;
                exp_q.push_back(e);
                m_busy[head.addr] = 1'b0;
            end
            if (iss && ia != 0) m_busy[ia] = 1'b1;
            if (push && da != 0) begin
                head.addr = da; head.data = dd;
                m_fifo.push_back(head);
            end
            m_stall = (blocked && m_wait >= MAX_WAIT - 1) || (m_fifo.size() == DEPTH);
            m_wait  = blocked ? m_wait + 1 : 0;
        end
        mon_en = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: just after each rising edge compare DUT outputs with the scoreboard and model.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rd_we", 64'(rd_we_o), 64'(e.we));
                    chk("rd_address", 64'(rd_address_o), 64'(e.addr));
                    chk("rd_data", 64'(rd_data_o), 64'(e.data));
                    $display("write we=%0d addr=%0d data=%08h", rd_we_o, rd_address_o, rd_data_o);
                end else begin
                    chk("rd_we_idle", 64'(rd_we_o), 64'(0));
                end
                chk("busy_mask", 64'(busy_mask_o), 64'(m_busy));
                chk("div_ready", 64'(div_ready_o), 64'(m_fifo.size() < DEPTH));
                chk("stall", 64'(stall_o), 64'(m_stall));
            end
        end
    end

    initial begin
        logic          r, pv, iss, dv;
        logic [AW-1:0] pa, ia, da;
        logic [DW-1:0] pd, dd;

        // Reset.
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Plain pipeline write.
        drive_cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("dir_pipe_we", 64'(rd_we_o), 64'(1));
        chk("dir_pipe_data", 64'(rd_data_o), 64'hDEADBEEF);
        idle(1);

        // Divider result with idle pipeline.
        drive_cycle(0, 0, 0, 0, 1, 7, 0, 0, 0);
        @(posedge clk); #2;
        chk("dir_busy7_set", 64'(busy_mask_o[7]), 64'(1));
        idle(2);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 7, 32'h12);
        idle(3);
        chk("dir_busy7_clr", 64'(busy_mask_o[7]), 64'(0));

        // Two results buffered behind a busy pipeline, drained in order.
        drive_cycle(0, 0, 0, 0, 1, 3, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 1, 4, 0, 0, 0);
        drive_cycle(0, 1, 10, 32'hA0, 0, 0, 1, 3, 32'h33);
        drive_cycle(0, 1, 11, 32'hA1, 0, 0, 1, 4, 32'h44);
        @(posedge clk); #2;
        chk("dir_full_ready", 64'(div_ready_o), 64'(0));
        chk("dir_full_stall", 64'(stall_o), 64'(1));
        drive_cycle(0, 1, 12, 32'hA2, 0, 0, 0, 0, 0);
        idle(4);

        // x0 traffic never writes and never buffers.
        drive_cycle(0, 1, 0, 32'h55, 1, 0, 1, 0, 32'h66);
        idle(2);

        // Single head starved by a continuously busy pipeline.
        drive_cycle(0, 0, 0, 0, 1, 9, 0, 0, 0);
        drive_cycle(0, 1, 13, 32'hB0, 0, 0, 1, 9, 32'h99);
        for (int i = 0; i < 6; i++) drive_cycle(0, 1, AW'(14 + i), DW'(i), 0, 0, 0, 0, 0);
        idle(3);

        // Reset with a full buffer and busy bits set.
        drive_cycle(0, 0, 0, 0, 1, 11, 0, 0, 0);
        drive_cycle(0, 1, 20, 32'hC0, 1, 12, 1, 11, 32'h111);
        drive_cycle(0, 1, 21, 32'hC1, 0, 0, 1, 12, 32'h222);
        drive_cycle(1, 1, 22, 32'hC2, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("dir_rst_busy", 64'(busy_mask_o), 64'(0));
        chk("dir_rst_ready", 64'(div_ready_o), 64'(1));
        idle(2);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 199) == 0);
            iss = 0; ia = '0;
            if ($urandom_range(0, 99) < 30) begin
                ia = AW'($urandom_range(1, NR - 1));
                iss = !(m_busy[ia] || in_outst(ia));
                if (!iss) ia = '0;
            end else if ($urandom_range(0, 99) < 3) begin
                iss = 1; ia = '0;
            end
            dv = 0; da = '0; dd = $urandom;
            if (outst.size() != 0 && $urandom_range(0, 99) < 40) begin
                dv = 1; da = outst[0];
            end else if ($urandom_range(0, 99) < 3) begin
                dv = 1; da = '0;
            end
            pv = 0; pa = '0; pd = $urandom;
            if ((!m_stall && $urandom_range(0, 99) < 60) || $urandom_range(0, 99) < 5) begin
                pv = 1;
                for (int t = 0; t < 4; t++) begin
                    pa = AW'($urandom_range(0, NR - 1));
                    if (pa == 0 || !(m_busy[pa] || in_outst(pa) || (iss && ia == pa))) break;
                    pa = '0;
                end
            end
            if (r) outst.delete();
            else begin
                if (dv && da != 0 && (m_fifo.size() < DEPTH)) void'(outst.pop_front());
                if (iss && ia != 0) outst.push_back(ia);
            end
            drive_cycle(r, pv, pa, pd, iss, ia, dv, da, dd);
        end
        idle(6);
        @(posedge clk); #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
